// File: rtl/vga_line_fetch.sv
`default_nettype none
//==============================================================================
// Module   : vga_line_fetch
// Purpose  : Prefetches framebuffer line N+1 into a ping-pong line buffer while
//            line N scans out, then expands RGB332 to RGB888 (2-cycle latency).
//            VGA_LINE_FETCH_TESTPAT_EN replaces the RGB source with colour bars.
// Revision : 1.0 - initial release
//==============================================================================
module vga_line_fetch #(
    parameter int H_PIX       = 640,
    parameter int V_PIX       = 480,
    parameter int HTOTAL      = 1600,
    parameter int VTOTAL      = 525,
    parameter int ADDR_W      = 18,
    parameter int FB_BASE     = 0,
    parameter int FETCH_START = 0
) (
    input  logic              clk50,
    input  logic              reset_n,
    input  logic [10:0]       hcount,
    input  logic [9:0]        vcount,
    input  logic              hs_n_in,
    input  logic              vs_n_in,
    input  logic              blank_n_in,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [15:0]       mem_rdata,
    output logic [7:0]        VGA_R,
    output logic [7:0]        VGA_G,
    output logic [7:0]        VGA_B,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK_n,
    output logic              underrun
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_REQ  = 2'd1;
    localparam logic [1:0] c_S_WAIT = 2'd2;
    localparam logic [1:0] c_S_DONE = 2'd3;

    localparam logic [8:0] c_LAST_WORD = 9'(H_PIX / 2 - 1);
    localparam int         c_BAR_CYC   = H_PIX / 4;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [8:0]        r_word;
    logic              r_buf_sel;
    logic [ADDR_W-1:0] r_addr;
    logic              r_underrun;
    logic              w_wr_en;
    logic              w_underrun_set;
    logic [9:0]        w_next_line;
    logic              w_start;
    logic              w_line_end;
    logic [ADDR_W-1:0] w_line_ext;
    logic [ADDR_W-1:0] w_line_addr;

    logic [15:0]       r_lbuf [0:1023];
    logic [15:0]       r_rd_word;
    logic              r_byte_sel;
    logic              r_hs_d1;
    logic              r_vs_d1;
    logic              r_blank_d1;
    logic [7:0]        w_pix;
    logic [23:0]       w_rgb;

    assign w_next_line = (vcount == 10'(VTOTAL - 1)) ? 10'd0 : vcount + 10'd1;
    assign w_start     = (hcount == 11'(FETCH_START)) && (w_next_line < 10'(V_PIX));
    assign w_line_end  = (hcount == 11'(HTOTAL - 1));
    assign w_line_ext  = ADDR_W'(w_next_line);
    // line*320 as two shifts keeps the address path multiplier-free
    assign w_line_addr = ADDR_W'(FB_BASE) + (w_line_ext << 8) + (w_line_ext << 6);

    assign mem_rd   = (r_state == c_S_REQ);
    assign mem_addr = r_addr;
    assign underrun = r_underrun;

    always_comb begin
        w_state_nxt    = r_state;
        w_wr_en        = 1'b0;
        w_underrun_set = 1'b0;
        case (r_state)
            c_S_IDLE: if (w_start) w_state_nxt = c_S_REQ;
            c_S_REQ: begin
                if (w_line_end) begin
                    w_state_nxt    = c_S_IDLE;
                    w_underrun_set = 1'b1;
                end else if (mem_gnt) begin
                    w_state_nxt = c_S_WAIT;
                end
            end
            c_S_WAIT: begin
                if (w_line_end) begin
                    w_state_nxt    = c_S_IDLE;
                    w_underrun_set = 1'b1;
                end else if (mem_rvalid) begin
                    w_wr_en     = 1'b1;
                    w_state_nxt = (r_word == c_LAST_WORD) ? c_S_DONE : c_S_REQ;
                end
            end
            default: if (w_line_end) w_state_nxt = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_S_IDLE;
            r_word     <= 9'd0;
            r_buf_sel  <= 1'b0;
            r_addr     <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_underrun_set) r_underrun <= 1'b1;
            if (r_state == c_S_IDLE && w_start) begin
                r_word    <= 9'd0;
                r_buf_sel <= w_next_line[0];
                r_addr    <= w_line_addr;
            end else if (w_wr_en && r_word != c_LAST_WORD) begin
                r_word <= r_word + 9'd1;
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    // Line RAM is deliberately not reset so it maps onto block RAM
    always_ff @(posedge clk50) begin
        if (w_wr_en) r_lbuf[{r_buf_sel, r_word}] <= mem_rdata;
        r_rd_word <= r_lbuf[{vcount[0], hcount[10:2]}];
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            r_byte_sel  <= 1'b0;
            r_hs_d1     <= 1'b1;
            r_vs_d1     <= 1'b1;
            r_blank_d1  <= 1'b0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_n <= 1'b0;
            VGA_R       <= 8'd0;
            VGA_G       <= 8'd0;
            VGA_B       <= 8'd0;
        end else begin
            r_byte_sel  <= hcount[1];
            r_hs_d1     <= hs_n_in;
            r_vs_d1     <= vs_n_in;
            r_blank_d1  <= blank_n_in;
            VGA_HS      <= r_hs_d1;
            VGA_VS      <= r_vs_d1;
            VGA_BLANK_n <= r_blank_d1;
            {VGA_R, VGA_G, VGA_B} <= r_blank_d1 ? w_rgb : 24'd0;
        end
    end

    assign w_pix = r_byte_sel ? r_rd_word[15:8] : r_rd_word[7:0];

`ifdef VGA_LINE_FETCH_TESTPAT_EN
    logic [2:0] w_bar;
    logic [2:0] r_bar;

    always_comb begin
        w_bar = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (hcount >= 11'(i * c_BAR_CYC)) w_bar = 3'(i);
        end
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) r_bar <= 3'd0;
        else          r_bar <= w_bar;
    end

    always_comb begin
        w_rgb = 24'h000000;
        case (r_bar)
            3'd0:    w_rgb = 24'hFFFFFF;
            3'd1:    w_rgb = 24'hFFFF00;
            3'd2:    w_rgb = 24'h00FFFF;
            3'd3:    w_rgb = 24'h00FF00;
            3'd4:    w_rgb = 24'hFF00FF;
            3'd5:    w_rgb = 24'hFF0000;
            3'd6:    w_rgb = 24'h0000FF;
            default: w_rgb = 24'h000000;
        endcase
    end
`else
    assign w_rgb = {w_pix[7:5], w_pix[7:5], w_pix[7:6],
                    w_pix[4:2], w_pix[4:2], w_pix[4:3],
                    {4{w_pix[1:0]}}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_line_fetch.sv
`default_nettype none
//==============================================================================
// Module   : tb_vga_line_fetch
// Purpose  : Self-checking bench for vga_line_fetch: table of raster lines with
//            a randomized memory responder and a framebuffer reference model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_vga_line_fetch;

    localparam int FB_BASE = 0;

    logic        clk50 = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] hcount = 11'd0;
    logic [9:0]  vcount = 10'd0;
    logic        hs_n_in = 1'b1;
    logic        vs_n_in = 1'b1;
    logic        blank_n_in = 1'b0;
    logic        mem_rd;
    logic [17:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [15:0] mem_rdata = 16'd0;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, VGA_BLANK_n;
    logic        underrun;

    always #5 clk50 = ~clk50;

    vga_line_fetch dut (
        .clk50(clk50), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
        .hs_n_in(hs_n_in), .vs_n_in(vs_n_in), .blank_n_in(blank_n_in),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_n(VGA_BLANK_n),
        .underrun(underrun)
    );

    typedef struct {
        int hc;
        int v;
        logic blank;
        logic hs;
        logic vs;
    } in_t;

    typedef struct {
        int v;
        int mode;       // 0 never grant, 1 fixed 1-cycle, 2 random latency
        int rst_at;     // hcount at which reset is pulsed, -1 none
        int exp_reqs;
        int exp_addr0;
        logic exp_ur;
    } row_t;

    int   checks = 0;
    int   errors = 0;
    int   mem_mode = 1;
    int   grants = 0;
    int   first_addr = -1;
    int   buf_line [2];
    in_t  prev, cur;
    bit   have_prev = 0;

    function automatic logic [15:0] fb_word(input logic [17:0] a);
        logic [31:0] x;
        if (a == 18'(FB_BASE)) return 16'h1CE0;
        x = {14'd0, a} * 32'h0000_9E37 + 32'h0000_5A5A;
        return x[23:8];
    endfunction

    function automatic logic [23:0] expand(input logic [7:0] p);
        return {p[7:5], p[7:5], p[7:6], p[4:2], p[4:2], p[4:3], {4{p[1:0]}}};
    endfunction

    function automatic logic [23:0] pix_model(input int hc, input int v);
        logic [15:0] w;
        int pixel;
        pixel = hc / 2;
        w = fb_word(18'(FB_BASE + v * 320 + pixel / 2));
        return expand((pixel % 2 == 1) ? w[15:8] : w[7:0]);
    endfunction

    function automatic logic [23:0] bar_rgb(input int idx);
        logic [23:0] t [8];
        t = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        return t[idx];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input in_t e);
        logic [23:0] rgb;
        rgb = {VGA_R, VGA_G, VGA_B};
        chk("sync", {29'd0, VGA_HS, VGA_VS, VGA_BLANK_n}, {29'd0, e.hs, e.vs, e.blank});
        if (!e.blank) begin
            chk("rgb_blank", {8'd0, rgb}, 32'd0);
        end else begin
`ifdef VGA_LINE_FETCH_TESTPAT_EN
            chk("rgb_bar", {8'd0, rgb}, {8'd0, bar_rgb(e.hc / 160)});
`else
            if (buf_line[e.v % 2] == e.v)
                chk("rgb_pix", {8'd0, rgb}, {8'd0, pix_model(e.hc, e.v)});
`endif
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_rgb"}, {8'd0, VGA_R, VGA_G, VGA_B}, 32'd0);
        chk({tag, "_hs_vs_blank"}, {29'd0, VGA_HS, VGA_VS, VGA_BLANK_n}, 32'h6);
        chk({tag, "_underrun"}, 32'(underrun), 32'd0);
    endtask

    // Memory responder: one outstanding request, latency chosen by mem_mode
    initial begin : responder
        int g_wait;
        int rv_cnt;
        logic [15:0] pend;
        g_wait = 0;
        rv_cnt = 0;
        pend = 16'd0;
        forever begin
            @(negedge clk50);
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = pend;
                end
            end else if (mem_rd && mem_mode != 0) begin
                if (g_wait == 0) begin
                    mem_gnt = 1'b1;
                    pend = fb_word(mem_addr);
                    if (grants == 0) first_addr = int'(mem_addr);
                    grants++;
                    rv_cnt = (mem_mode == 2) ? int'($urandom_range(2, 1)) : 1;
                    g_wait = (mem_mode == 2) ? int'($urandom_range(1, 0)) : 1;
                end else begin
                    g_wait--;
                end
            end
        end
    end

    task automatic run_line(input row_t r);
        int nl;
        bit fetch;
        nl = (r.v == 524) ? 0 : r.v + 1;
        fetch = (nl < 480);
        mem_mode = r.mode;
        grants = 0;
        first_addr = -1;
        if (fetch) buf_line[nl % 2] = -1;
        for (int h = 0; h < 1600; h++) begin
            cur.hc = h;
            cur.v = r.v;
            cur.blank = (r.v < 480) && (h < 1280);
            cur.hs = !(h >= 1312 && h < 1504);
            cur.vs = !(r.v == 490 || r.v == 491);
            hcount = 11'(h);
            vcount = 10'(r.v);
            hs_n_in = cur.hs;
            vs_n_in = cur.vs;
            blank_n_in = cur.blank;
            @(negedge clk50);
            if (have_prev) begin
                check_out(prev);
                if (prev.v == 0 && prev.hc < 4 && buf_line[0] == 0)
                    chk("pixel01", {8'd0, VGA_R, VGA_G, VGA_B},
                        (prev.hc < 2) ? 32'h00FF0000 : 32'h0000FF00);
            end
            prev = cur;
            have_prev = 1;
            if (h == r.rst_at) begin
                chk("pre_reset_rd", 32'(mem_rd), 32'd1);
                #2 reset_n = 1'b0;
                #1 check_reset_state("midreset");
                #1 reset_n = 1'b1;
                have_prev = 0;
            end
        end
        chk("grants", grants, r.exp_reqs);
        if (r.exp_reqs > 0) chk("addr0", first_addr, r.exp_addr0);
        chk("underrun", 32'(underrun), 32'(r.exp_ur));
        chk("rd_after_line", 32'(mem_rd), 32'd0);
        if (fetch && r.mode != 0) buf_line[nl % 2] = nl;
    endtask

    initial begin : main
        row_t rows [19];
        rows = '{
            '{524, 1, -1, 320, 0,      1'b0},
            '{0,   2, -1, 320, 320,    1'b0},
            '{1,   2, -1, 320, 640,    1'b0},
            '{2,   0, -1, 0,   0,      1'b1},
            '{3,   1, -1, 320, 1280,   1'b1},
            '{4,   1, -1, 320, 1600,   1'b1},
            '{5,   2, -1, 320, 1920,   1'b1},
            '{9,   1, -1, 320, 3200,   1'b1},
            '{10,  0, 40, 0,   0,      1'b0},
            '{11,  1, -1, 320, 3840,   1'b0},
            '{12,  2, -1, 320, 4160,   1'b0},
            '{477, 1, -1, 320, 152960, 1'b0},
            '{478, 2, -1, 320, 153280, 1'b0},
            '{479, 1, -1, 0,   0,      1'b0},
            '{480, 1, -1, 0,   0,      1'b0},
            '{500, 1, -1, 0,   0,      1'b0},
            '{523, 1, -1, 0,   0,      1'b0},
            '{524, 2, -1, 320, 0,      1'b0},
            '{0,   1, -1, 320, 320,    1'b0}
        };
        buf_line[0] = -1;
        buf_line[1] = -1;
        reset_n = 1'b0;
        repeat (3) @(negedge clk50);
        check_reset_state("reset");
        #2 reset_n = 1'b1;
        for (int i = 0; i < 19; i++) run_line(rows[i]);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
